target_detect_core: RTL
=======================

TARGET_DETECT_CORE -- requirements
Module: target_detect_core

Interface
REQ-001 The block SHALL have parameter WIN, default 16, giving the sliding-window length in range bins, legal range 2..64.
REQ-002 The block SHALL have parameter AW, default 10, giving the range-bin address width.
REQ-003 The block SHALL have parameter TW, default 8, giving the threshold width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a sweep.
REQ-007 The block SHALL have port bin_valid, input, 1 bit: the bin_* inputs are valid this cycle.
REQ-008 The block SHALL have port bin_bit, input, 1 bit: quantised echo hit for the current bin.
REQ-009 The block SHALL have port bin_mask, input, 1 bit: 1 = bin usable, 0 = bin in a shield zone.
REQ-010 The block SHALL have port bin_addr, input, AW bits: range-bin address of the current bin.
REQ-011 The block SHALL have port bin_last, input, 1 bit: qualified by bin_valid; marks the final bin of the sweep.
REQ-012 The block SHALL have ports thresh_start and thresh_end, input, TW bits each: hit-count thresholds for target start and target end.
REQ-013 The block SHALL have ports target_start and target_end, output, 1 bit each: one-cycle event pulses.
REQ-014 The block SHALL have port tgt_addr, output, AW bits: bin address of the most recent event.
REQ-015 The block SHALL have port tgt_count, output, 8 bits: number of targets closed in the current sweep.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a sweep is active.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep.

Function
REQ-018 Effective hit: hit = bin_bit AND bin_mask; a masked bin enters the window as 0.
REQ-019 Window: a WIN-bit shift register advanced only on bin_valid; it holds unchanged while bin_valid=0.
REQ-020 Count: count_next = count + hit - oldest bit; width clog2(WIN+1); count never exceeds WIN.
REQ-021 Comparisons SHALL zero-extend count_next to TW bits.
REQ-022 States SHALL be IDLE, SCAN, TGT and FIN.
REQ-023 IDLE: on start, clear window, count and tgt_count, then go to SCAN; start in any other state is ignored.
REQ-024 SCAN, on bin_valid: if thresh_start != 0 and count_next >= thresh_start, pulse target_start, load tgt_addr = bin_addr and go to TGT.
REQ-025 TGT, on bin_valid: if count_next <= thresh_end, pulse target_end, load tgt_addr = bin_addr, increment tgt_count (saturating at 255) and go to SCAN.
REQ-026 Latency: every output event SHALL be registered and appear exactly 1 cycle after the bin_valid edge that caused it.
REQ-027 bin_valid with bin_last: process the bin normally (REQ-024/025), then handle end of sweep as follows.
REQ-027a If the resulting state is TGT, force target_end at that bin_addr and increment tgt_count.
REQ-027b Pulse done in the same cycle and go to FIN.
REQ-028 A start and forced end on the same last bin SHALL assert target_start and target_end together, with tgt_addr = bin_addr.
REQ-029 FIN SHALL return to IDLE after 1 cycle; tgt_count and tgt_addr hold until the next start.
REQ-030 thresh_start = 0 or thresh_start > WIN SHALL mean no detection.
REQ-031 Thresholds SHALL be sampled each bin and SHALL NOT be latched.
REQ-032 bin_valid in IDLE or FIN SHALL be ignored.
REQ-033 busy = 1 in SCAN and TGT, 0 otherwise.

Reset
REQ-034 Asserting reset (low) SHALL immediately force state IDLE, clear window and count, set all outputs to 0 (tgt_addr = 0, tgt_count = 0), and abandon any sweep in progress with no pulses.
REQ-035 After deassertion the block SHALL wait for a new start.

Verification
REQ-036 WIN=8, thresh 5/2, mask=1, bins 0..19 with hits on 4..11, last=19 -> target_start at addr 8; target_end at addr 17; done after bin 19; tgt_count = 1.
REQ-037 Same stimulus but bin_mask=0 on bins 6..7 -> target_start at addr 10 (hits 4,5,8,9,10).
REQ-038 WIN=8, thresh 3/1, hits on bins 15..19, last=19 -> target_start at 17; forced target_end at 19 together with done; tgt_count = 1.
REQ-039 Gaps: insert bin_valid=0 cycles between bins of REQ-036 -> identical events and addresses; start pulsed mid-sweep is ignored.
REQ-040 Reset low while in TGT -> all outputs 0 at once and no target_end; a new start then repeats REQ-036 exactly.
REQ-041 thresh_start = 0 or 9 with all hits -> no target_start; done asserted; tgt_count = 0.

Source files
------------

// File: rtl/target_detect_core.sv
`default_nettype none
// ============================================================================
//  Module      : target_detect_core
//  Description : Sliding-window M-of-N target detector over a range sweep.
//                Masked echo hits enter a WIN-bin window. A running hit count
//                opens a target when it reaches thresh_start and closes it
//                when it falls to thresh_end. A target still open at the
//                last bin is force-closed. Every event is a registered pulse
//                one cycle after the bin that caused it.
//  Revision    : 1.0 - initial release
// ============================================================================
module target_detect_core #(
    parameter int WIN = 16,
    parameter int AW  = 10,
    parameter int TW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          bin_valid,
    input  logic          bin_bit,
    input  logic          bin_mask,
    input  logic [AW-1:0] bin_addr,
    input  logic          bin_last,
    input  logic [TW-1:0] thresh_start,
    input  logic [TW-1:0] thresh_end,
    output logic          target_start,
    output logic          target_end,
    output logic [AW-1:0] tgt_addr,
    output logic [7:0]    tgt_count,
    output logic          busy,
    output logic          done
);

    // Count width, and a common compare width wide enough for both the
    // count and the thresholds so that neither side is truncated.
    localparam int c_CW = $clog2(WIN + 1);
    localparam int c_XW = (TW > c_CW) ? TW : c_CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_TGT  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIN-1:0]    r_win;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_next;
    logic              w_hit;
    logic              w_oldest;

    logic [c_XW-1:0]   w_cnt_ext;
    logic [c_XW-1:0]   w_ts_ext;
    logic [c_XW-1:0]   w_te_ext;
    logic              w_ts_hit;
    logic              w_te_hit;

    logic              w_clear;
    logic              w_adv;
    logic              w_ev_start;
    logic              w_ev_end;
    logic              w_ev_done;

    logic              r_target_start;
    logic              r_target_end;
    logic              r_done;
    logic [AW-1:0]     r_tgt_addr;
    logic [7:0]        r_tgt_count;

    // A shielded bin contributes nothing to the window.
    assign w_hit    = bin_bit & bin_mask;
    assign w_oldest = r_win[WIN-1];

    // The count tracks the popcount of the window, so it is bounded by WIN.
    assign w_count_next = r_count + {{(c_CW-1){1'b0}}, w_hit}
                                  - {{(c_CW-1){1'b0}}, w_oldest};

    // Unsigned zero-extension before comparing against the thresholds.
    assign w_cnt_ext = c_XW'(w_count_next);
    assign w_ts_ext  = c_XW'(thresh_start);
    assign w_te_ext  = c_XW'(thresh_end);

    // thresh_start of zero disables detection; values above WIN are never
    // reachable because the count cannot exceed WIN.
    assign w_ts_hit  = (thresh_start != '0) && (w_cnt_ext >= w_ts_ext);
    assign w_te_hit  = (w_cnt_ext <= w_te_ext);

    // Next-state and event decode.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_adv        = 1'b0;
        w_ev_start   = 1'b0;
        w_ev_end     = 1'b0;
        w_ev_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bin_valid) begin
                    w_adv = 1'b1;
                    if (w_ts_hit) begin
                        w_ev_start   = 1'b1;
                        w_state_next = ST_TGT;
                    end
                    // A target opened on the last bin is closed right away.
                    if (bin_last) begin
                        if (w_ts_hit) begin
                            w_ev_end = 1'b1;
                        end
                        w_ev_done    = 1'b1;
                        w_state_next = ST_FIN;
                    end
                end
            end
            ST_TGT: begin
                if (bin_valid) begin
                    w_adv = 1'b1;
                    if (w_te_hit) begin
                        w_ev_end     = 1'b1;
                        w_state_next = ST_SCAN;
                    end
                    // Last bin: close the target whether or not the count
                    // dropped; a natural close and a forced close coincide.
                    if (bin_last) begin
                        w_ev_end     = 1'b1;
                        w_ev_done    = 1'b1;
                        w_state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sliding window and running hit count; frozen when no bin is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win   <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_win   <= '0;
            r_count <= '0;
        end else if (w_adv) begin
            r_win   <= {r_win[WIN-2:0], w_hit};
            r_count <= w_count_next;
        end
    end

    // One-cycle event pulses, registered one cycle after the causing bin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target_start <= 1'b0;
            r_target_end   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_target_start <= w_ev_start;
            r_target_end   <= w_ev_end;
            r_done         <= w_ev_done;
        end
    end

    // Event address and saturating per-sweep target counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tgt_addr  <= '0;
            r_tgt_count <= '0;
        end else begin
            if (w_ev_start || w_ev_end) begin
                r_tgt_addr <= bin_addr;
            end
            if (w_clear) begin
                r_tgt_count <= '0;
            end else if (w_ev_end && (r_tgt_count != 8'hFF)) begin
                r_tgt_count <= r_tgt_count + 8'd1;
            end
        end
    end

    assign target_start = r_target_start;
    assign target_end   = r_target_end;
    assign done         = r_done;
    assign tgt_addr     = r_tgt_addr;
    assign tgt_count    = r_tgt_count;
    assign busy         = (r_state == ST_SCAN) || (r_state == ST_TGT);

endmodule
`default_nettype wire
